pwm_sequencer: RTL and testbench

//  Controller for a bank of NUM_CH pwm_generator channels. Owns the shared 8-bit period

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_ramp_step.sv | 33 +++
 rtl/pwm_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pwm_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequencer: register map, CTRL bit positions
// and the sequencer FSM state encoding.
package pwm_pkg;

  localparam logic [3:0] ADDR_CTRL        = 4'd0;
  localparam logic [3:0] ADDR_PRESCALE    = 4'd1;
  localparam logic [3:0] ADDR_RAMP_STEP   = 4'd2;
  localparam logic [3:0] ADDR_CH_MASK     = 4'd3;
  localparam logic [3:0] ADDR_TARGET_BASE = 4'd8;

  localparam int unsigned CTRL_RUN_BIT     = 0;
  localparam int unsigned CTRL_RAMP_EN_BIT = 1;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Next committed duty for one channel: jump straight to target when ramping is
// off (or step is zero), otherwise move one step toward target without
// overshooting. Differences are formed in 9 bits so no wrap can occur.
module pwm_ramp_step (
  input  logic [7:0] duty_i,
  input  logic [7:0] target_i,
  input  logic [7:0] step_i,
  input  logic       ramp_en_i,
  output logic [7:0] next_duty_o
);

  logic [8:0] diff;

  // Select target, duty+step or duty-step depending on distance to target.
  always_comb begin
    next_duty_o = target_i;
    diff        = '0;
    if (ramp_en_i && (step_i != '0)) begin
      if (target_i >= duty_i) begin
        diff = {1'b0, target_i} - {1'b0, duty_i};
        if (diff > {1'b0, step_i}) begin
          next_duty_o = duty_i + step_i;
        end
      end else begin
        diff = {1'b0, duty_i} - {1'b0, target_i};
        if (diff > {1'b0, step_i}) begin
          next_duty_o = duty_i - step_i;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// Controller for a bank of pwm_generator channels: shared prescaler and 8-bit
// period counter, host-written shadow registers, and a STOPPED/RUNNING/DRAIN
// FSM that commits enables and duties only at period wrap (or run entry).
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_addr,
  input  logic [7:0]            cfg_wdata,
  output logic [7:0]            counter,
  output logic                  period_wrap,
  output logic [NUM_CH-1:0]     ch_enable,
  output logic [8*NUM_CH-1:0]   ch_duty,
  output logic                  busy
);

  // Shadow registers
  logic [1:0]        ctrl_q;
  logic [7:0]        prescale_q;
  logic [7:0]        step_q;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        target_q [NUM_CH];

  // Sequencer state and registered outputs
  state_e            state_q, state_d;
  logic [7:0]        presc_q, presc_d;
  logic [7:0]        counter_q, counter_d;
  logic              wrap_q, wrap_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [7:0]        duty_q [NUM_CH];
  logic [7:0]        duty_d [NUM_CH];
  logic [7:0]        ramp_duty [NUM_CH];

  logic run, ramp_en, tick, entry, wrap_commit, wr_en;

  assign run     = ctrl_q[CTRL_RUN_BIT];
  assign ramp_en = ctrl_q[CTRL_RAMP_EN_BIT];
  // A count above a freshly lowered PRESCALE must still tick immediately.
  assign tick    = (presc_q >= prescale_q);
  // Commit happens in the cycle the wrap pulse is visible, or on run entry.
  assign entry       = (state_q == ST_STOPPED) && run;
  assign wrap_commit = wrap_q;
  assign cfg_ready   = !(entry || wrap_commit);
  assign wr_en       = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ramp
    pwm_ramp_step u_ramp (
      .duty_i      (duty_q[g]),
      .target_i    (target_q[g]),
      .step_i      (step_q),
      .ramp_en_i   (ramp_en),
      .next_duty_o (ramp_duty[g])
    );
  end

  // Host writes into the shadow register set; unmapped addresses are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      step_q     <= '0;
      mask_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) target_q[i] <= '0;
    end else if (wr_en) begin
      case (cfg_addr)
        ADDR_CTRL:      ctrl_q     <= cfg_wdata[1:0];
        ADDR_PRESCALE:  prescale_q <= cfg_wdata;
        ADDR_RAMP_STEP: step_q     <= cfg_wdata;
        ADDR_CH_MASK:   mask_q     <= cfg_wdata[NUM_CH-1:0];
        default: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == (ADDR_TARGET_BASE + 4'(i))) target_q[i] <= cfg_wdata;
          end
        end
      endcase
    end
  end

  // Next-state logic for FSM, timebase and committed channel settings.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    counter_d = counter_q;
    wrap_d    = 1'b0;
    enable_d  = enable_q;
    duty_d    = duty_q;
    unique case (state_q)
      ST_STOPPED: begin
        presc_d   = '0;
        counter_d = '0;
        enable_d  = '0;
        if (run) begin
          state_d  = ST_RUNNING;
          enable_d = mask_q;
          duty_d   = target_q;
        end
      end
      ST_RUNNING, ST_DRAIN: begin
        if (tick) begin
          presc_d   = '0;
          counter_d = counter_q + 8'd1;
          wrap_d    = (counter_q == 8'hFF);
        end else begin
          presc_d   = presc_q + 8'd1;
        end
        // RUN re-asserted in DRAIN revives the channel set instead of stopping.
        if (state_q == ST_RUNNING) begin
          if (!run) state_d = ST_DRAIN;
        end else if (run) begin
          state_d = ST_RUNNING;
        end
        if (wrap_commit) begin
          if ((state_q == ST_RUNNING) || run) begin
            enable_d = mask_q;
            duty_d   = ramp_duty;
          end else begin
            state_d   = ST_STOPPED;
            enable_d  = '0;
            presc_d   = '0;
            counter_d = '0;
            wrap_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Sequencer state and registered channel outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STOPPED;
      presc_q   <= '0;
      counter_q <= '0;
      wrap_q    <= 1'b0;
      enable_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      enable_q  <= enable_d;
      duty_q    <= duty_d;
    end
  end

  // Flatten duties onto the output bus and derive busy.
  always_comb begin
    ch_duty = '0;
    busy    = (state_q != ST_STOPPED);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_duty[8*i +: 8] = duty_q[i];
      if (duty_q[i] != target_q[i]) busy = 1'b1;
    end
  end

  assign counter     = counter_q;
  assign period_wrap = wrap_q;
  assign ch_enable   = enable_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed self-checking bench for pwm_sequencer with NUM_CH=4.
module tb_pwm_sequencer;

  localparam int unsigned NCH = 4;

  logic             clk;
  logic             reset_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_addr;
  logic [7:0]       cfg_wdata;
  logic [7:0]       counter;
  logic             period_wrap;
  logic [NCH-1:0]   ch_enable;
  logic [8*NCH-1:0] ch_duty;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int n;

  pwm_sequencer #(.NUM_CH(NCH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .counter     (counter),
    .period_wrap (period_wrap),
    .ch_enable   (ch_enable),
    .ch_duty     (ch_duty),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!cfg_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_wrap(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!period_wrap && cyc < 3000);
    check("wrap_seen", {31'd0, period_wrap}, 32'd1);
  endtask

  task automatic wait_counter(input logic [7:0] v);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (counter != v && cyc < 3000);
    check("counter_reach", {24'd0, counter}, {24'd0, v});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_counter", {24'd0, counter}, 32'd0);
    check("rst_wrap",    {31'd0, period_wrap}, 32'd0);
    check("rst_enable",  {28'd0, ch_enable}, 32'd0);
    check("rst_duty",    ch_duty, 32'd0);
    check("rst_ready",   {31'd0, cfg_ready}, 32'd1);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // Unmapped writes: nothing may change (a stray target write would raise busy).
    cfg_write(4'd5, 8'hFF);
    cfg_write(4'd12, 8'hFF);
    @(negedge clk);
    check("unmapped_busy", {31'd0, busy}, 32'd0);
    check("unmapped_duty", ch_duty, 32'd0);
    check("unmapped_cnt",  {24'd0, counter}, 32'd0);

    // Basic start: PRESCALE=0, TARGET0=64, MASK=1, RUN.
    cfg_write(4'd1, 8'd0);
    cfg_write(4'd8, 8'd64);
    @(negedge clk);
    check("busy_target_pending", {31'd0, busy}, 32'd1);
    cfg_write(4'd3, 8'h01);
    cfg_write(4'd0, 8'h01);
    @(negedge clk);
    check("entry_ready_low", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    check("entry_duty0",  {24'd0, ch_duty[7:0]}, 32'd64);
    check("entry_enable", {28'd0, ch_enable}, 32'd1);
    check("entry_cnt",    {24'd0, counter}, 32'd0);
    check("entry_ready",  {31'd0, cfg_ready}, 32'd1);
    wait_wrap(n);
    check("first_period", n, 32'd256);
    check("wrap_cnt0",    {24'd0, counter}, 32'd0);
    check("wrap_ready",   {31'd0, cfg_ready}, 32'd0);
    wait_wrap(n);
    check("period_ps0", n, 32'd256);

    // Prescale 3: period of 1024 clocks once aligned.
    cfg_write(4'd1, 8'd3);
    wait_wrap(n);
    wait_wrap(n);
    check("period_ps3", n, 32'd1024);
    cfg_write(4'd1, 8'd0);
    wait_wrap(n);

    // Mid-period target write commits only at wrap.
    cfg_write(4'd3, 8'h03);
    wait_counter(8'd100);
    cfg_write(4'd9, 8'd200);
    @(negedge clk);
    check("mid_duty1_hold", {24'd0, ch_duty[15:8]}, 32'd0);
    check("mid_enable_hold", {28'd0, ch_enable}, 32'd1);
    wait_wrap(n);
    check("wrap_duty1_hold", {24'd0, ch_duty[15:8]}, 32'd0);
    check("commit_ready_low", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    check("commit_duty1", {24'd0, ch_duty[15:8]}, 32'd200);
    check("commit_enable", {28'd0, ch_enable}, 32'd3);
    check("commit_ready_back", {31'd0, cfg_ready}, 32'd1);

    // Ramp 10 -> 45 in steps of 16, then back to 0.
    cfg_write(4'd8, 8'd10);
    wait_wrap(n);
    @(negedge clk);
    check("ramp_start", {24'd0, ch_duty[7:0]}, 32'd10);
    cfg_write(4'd2, 8'd16);
    cfg_write(4'd0, 8'h03);
    cfg_write(4'd8, 8'd45);
    wait_wrap(n); @(negedge clk);
    check("ramp_up1", {24'd0, ch_duty[7:0]}, 32'd26);
    wait_wrap(n); @(negedge clk);
    check("ramp_up2", {24'd0, ch_duty[7:0]}, 32'd42);
    wait_wrap(n); @(negedge clk);
    check("ramp_up3", {24'd0, ch_duty[7:0]}, 32'd45);
    cfg_write(4'd8, 8'd0);
    wait_wrap(n); @(negedge clk);
    check("ramp_dn1", {24'd0, ch_duty[7:0]}, 32'd29);
    wait_wrap(n); @(negedge clk);
    check("ramp_dn2", {24'd0, ch_duty[7:0]}, 32'd13);
    wait_wrap(n); @(negedge clk);
    check("ramp_dn3", {24'd0, ch_duty[7:0]}, 32'd0);

    // Stop at counter 50: drain to wrap, then idle.
    wait_counter(8'd50);
    cfg_write(4'd0, 8'h02);
    @(negedge clk);
    check("drain_counting", {24'd0, counter}, 32'd52);
    check("drain_busy", {31'd0, busy}, 32'd1);
    wait_wrap(n);
    check("drain_wrap_enable", {28'd0, ch_enable}, 32'd3);
    @(negedge clk);
    check("stop_enable", {28'd0, ch_enable}, 32'd0);
    check("stop_cnt",    {24'd0, counter}, 32'd0);
    check("stop_busy",   {31'd0, busy}, 32'd0);
    check("stop_duty",   ch_duty, 32'h0000_C800);
    repeat (3) @(negedge clk);
    check("stop_cnt_held", {24'd0, counter}, 32'd0);
    check("stop_no_wrap",  {31'd0, period_wrap}, 32'd0);

    // Restart with ramp enabled: entry bypasses the ramp.
    cfg_write(4'd8, 8'd77);
    @(negedge clk);
    check("stopped_busy_target", {31'd0, busy}, 32'd1);
    cfg_write(4'd0, 8'h03);
    @(negedge clk);
    @(negedge clk);
    check("reentry_duty0", {24'd0, ch_duty[7:0]}, 32'd77);
    check("reentry_enable", {28'd0, ch_enable}, 32'd3);

    // RUN cleared then set again before the wrap keeps running.
    wait_counter(8'd50);
    cfg_write(4'd0, 8'h02);
    wait_counter(8'd100);
    cfg_write(4'd0, 8'h03);
    wait_wrap(n);
    @(negedge clk);
    check("revive_enable", {28'd0, ch_enable}, 32'd3);
    check("revive_cnt",    {24'd0, counter}, 32'd1);

    // Asynchronous reset while running.
    wait_counter(8'd30);
    #2 reset_n = 1'b0;
    #1;
    check("arst_counter", {24'd0, counter}, 32'd0);
    check("arst_enable",  {28'd0, ch_enable}, 32'd0);
    check("arst_duty",    ch_duty, 32'd0);
    check("arst_wrap",    {31'd0, period_wrap}, 32'd0);
    check("arst_ready",   {31'd0, cfg_ready}, 32'd1);
    check("arst_busy",    {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_cnt",   {24'd0, counter}, 32'd0);
    check("post_rst_ready", {31'd0, cfg_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
